// File: rtl/reg_block_mover_pkg.sv
// Shared constants and types for the multi-register save/restore sequencer.
package reg_block_mover_pkg;

    localparam int WORD_SIZE = 16;
    localparam int REG_BITS  = 3;
    localparam int NREGS     = 1 << REG_BITS;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic DIR_SAVE    = 1'b0;
    localparam logic DIR_RESTORE = 1'b1;

endpackage

// File: rtl/reg_block_mover_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a register mask.
module lowest_set_bit
    import reg_block_mover_pkg::*;
(
    input  logic [NREGS-1:0]    vec,
    output logic [REG_BITS-1:0] idx,
    output logic                valid
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = REG_BITS'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_block_mover.sv
// Walks a register bitmask in ascending order, moving each selected register
// to consecutive memory words (save) or back from memory (restore).
module reg_block_mover
    import reg_block_mover_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dir,
    input  logic [NREGS-1:0]     mask,
    input  logic [WORD_SIZE-1:0] base_addr,
    output logic                 busy,
    output logic                 done,
    output logic [REG_BITS:0]    xfer_count,
    output logic [REG_BITS-1:0]  rf_read_reg,
    input  logic [WORD_SIZE-1:0] rf_read_data,
    output logic                 rf_write_en,
    output logic [REG_BITS-1:0]  rf_write_reg,
    output logic [WORD_SIZE-1:0] rf_write_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    localparam logic [REG_BITS:0] COUNT_ONE = 1;

    state_t               state, state_next;
    logic [NREGS-1:0]     pending, pending_clr;
    logic [WORD_SIZE-1:0] addr;
    logic                 dir_q;
    logic [REG_BITS-1:0]  idx;
    logic                 idx_valid;
    logic                 ack_fire;

    lowest_set_bit u_lsb (
        .vec   (pending),
        .idx   (idx),
        .valid (idx_valid)
    );

    assign pending_clr = pending & ~(NREGS'(1) << idx);
    assign ack_fire    = (state == REQ) && mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // An empty mask skips straight to DONE so the control unit still sees a pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (mask != '0) ? REQ : DONE;
            end
            REQ: begin
                if (!idx_valid)                                state_next = DONE;
                else if (mem_ack && (pending_clr == '0))       state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Restore writes land one cycle after their ack, so the last one overlaps DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending       <= '0;
            addr          <= '0;
            dir_q         <= DIR_SAVE;
            xfer_count    <= '0;
            rf_write_en   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            rf_write_en <= 1'b0;
            if ((state == IDLE) && start) begin
                xfer_count <= '0;
                if (mask != '0) begin
                    pending <= mask;
                    addr    <= base_addr;
                    dir_q   <= dir;
                end
            end
            if (ack_fire) begin
                pending    <= pending_clr;
                addr       <= addr + WORD_SIZE'(1);
                xfer_count <= xfer_count + COUNT_ONE;
                if (dir_q == DIR_RESTORE) begin
                    rf_write_en   <= 1'b1;
                    rf_write_reg  <= idx;
                    rf_write_data <= mem_rdata;
                end
            end
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign mem_req     = (state == REQ);
    assign mem_we      = mem_req && (dir_q == DIR_SAVE);
    assign mem_addr    = addr;
    assign mem_wdata   = mem_we ? rf_read_data : '0;
    assign rf_read_reg = idx;

endmodule

// File: tb/tb_reg_block_mover.sv
// Randomized self-checking bench for reg_block_mover with register-file and memory models.
module tb_reg_block_mover;
    import reg_block_mover_pkg::*;

    logic                 clk, rst, start, dir;
    logic [NREGS-1:0]     mask;
    logic [WORD_SIZE-1:0] base_addr;
    logic                 busy, done;
    logic [REG_BITS:0]    xfer_count;
    logic [REG_BITS-1:0]  rf_read_reg, rf_write_reg;
    logic [WORD_SIZE-1:0] rf_read_data, rf_write_data;
    logic                 rf_write_en;
    logic                 mem_req, mem_we, mem_ack;
    logic [WORD_SIZE-1:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] rf  [NREGS];
    logic [15:0] mem [65536];
    logic [15:0] exp_rf [NREGS];

    int checks, errors, cyc, req_cycles, done_count, stab_err, rfwe_idle_err;
    int ack_mode, req_ctr;
    logic        held, held_we;
    logic [15:0] held_addr, held_data;
    logic        pend_rf, pend_mem;
    logic [2:0]  pend_reg;
    logic [15:0] pend_rf_data, pend_mem_addr, pend_mem_data;
    int log_addr[$], log_data[$], log_we[$], ack_cyc[$];
    int rfw_reg[$], rfw_data[$], rfw_cyc[$];
    int exp_addr[$], exp_idx[$], exp_data[$];

    assign rf_read_data = rf[rf_read_reg];
    assign mem_rdata    = mem[mem_addr];

    reg_block_mover dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dir           (dir),
        .mask          (mask),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .xfer_count    (xfer_count),
        .rf_read_reg   (rf_read_reg),
        .rf_read_data  (rf_read_data),
        .rf_write_en   (rf_write_en),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Ack policy: 0 = zero-wait, 1 = random, 2 = ack on the 4th request cycle.
    task automatic driveAck();
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: mem_ack = ($urandom_range(0, 2) == 0);
            default: begin
                if (mem_req) begin
                    req_ctr++;
                    mem_ack = (req_ctr == 4);
                    if (req_ctr == 4) req_ctr = 0;
                end else begin
                    req_ctr = 0;
                    mem_ack = ($urandom_range(0, 1) == 1);
                end
            end
        endcase
    endtask

    task automatic sampleEdge();
        cyc++;
        if (rst) begin
            held = 1'b0;
            return;
        end
        if (mem_req) begin
            req_cycles++;
            if (held && (mem_addr !== held_addr || mem_we !== held_we ||
                         (held_we && mem_wdata !== held_data)))
                stab_err++;
            if (mem_ack) begin
                log_addr.push_back(int'(mem_addr));
                log_we.push_back(int'(mem_we));
                log_data.push_back(int'(mem_we ? mem_wdata : mem_rdata));
                ack_cyc.push_back(cyc);
                held = 1'b0;
                if (mem_we) begin
                    pend_mem      = 1'b1;
                    pend_mem_addr = mem_addr;
                    pend_mem_data = mem_wdata;
                end
            end else begin
                held      = 1'b1;
                held_addr = mem_addr;
                held_we   = mem_we;
                held_data = mem_wdata;
            end
        end else begin
            held = 1'b0;
        end
        if (rf_write_en) begin
            rfw_reg.push_back(int'(rf_write_reg));
            rfw_data.push_back(int'(rf_write_data));
            rfw_cyc.push_back(cyc);
            if (!busy) rfwe_idle_err++;
            pend_rf      = 1'b1;
            pend_reg     = rf_write_reg;
            pend_rf_data = rf_write_data;
        end
        if (done) done_count++;
    endtask

    task automatic tick();
        driveAck();
        #1;
        sampleEdge();
        @(posedge clk);
        if (pend_rf)  rf[pend_reg]       = pend_rf_data;
        if (pend_mem) mem[pend_mem_addr] = pend_mem_data;
        pend_rf  = 1'b0;
        pend_mem = 1'b0;
        @(negedge clk);
    endtask

    task automatic clearLogs();
        log_addr.delete(); log_data.delete(); log_we.delete(); ack_cyc.delete();
        rfw_reg.delete(); rfw_data.delete(); rfw_cyc.delete();
        exp_addr.delete(); exp_idx.delete(); exp_data.delete();
        req_cycles = 0;
    endtask

    task automatic applyStimulus(input logic d, input logic [NREGS-1:0] m, input logic [15:0] b,
                                 input int mode, input bit junk);
        int n, cycles, done_before;
        logic [15:0] a;
        ack_mode = mode;
        clearLogs();
        n = 0;
        for (int j = 0; j < NREGS; j++) exp_rf[j] = rf[j];
        for (int i = 0; i < NREGS; i++) begin
            if (m[i]) begin
                a = b + 16'(n);
                exp_addr.push_back(int'(a));
                exp_idx.push_back(i);
                if (d) begin
                    exp_data.push_back(int'(mem[a]));
                    exp_rf[i] = mem[a];
                end else begin
                    exp_data.push_back(int'(rf[i]));
                end
                n++;
            end
        end
        done_before = done_count;
        start = 1'b1; dir = d; mask = m; base_addr = b;
        tick();
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 600) begin
            if (junk && busy) begin
                start = 1'b1; dir = 1'($urandom_range(0, 1));
                mask = NREGS'($urandom); base_addr = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        checkOutput("done_seen", done, 1);
        if (mode == 0) begin
            checkOutput("latency", cycles, n + 1);
            checkOutput("req_cycles", req_cycles, n);
        end else if (mode == 2) begin
            checkOutput("latency_ws", cycles, 4 * n + 1);
            checkOutput("req_cycles_ws", req_cycles, 4 * n);
        end
        checkOutput("xfer_count", xfer_count, n);
        tick();
        checkOutput("done_pulse", done, 0);
        checkOutput("idle", busy, 0);
        checkOutput("xfer_hold", xfer_count, n);
        checkOutput("n_xfers", log_addr.size(), n);
        for (int k = 0; k < n && k < log_addr.size(); k++) begin
            checkOutput("xfer_addr", log_addr[k], exp_addr[k]);
            checkOutput("xfer_we", log_we[k], d ? 0 : 1);
            checkOutput("xfer_data", log_data[k], exp_data[k]);
        end
        checkOutput("n_rf_writes", rfw_reg.size(), d ? n : 0);
        for (int k = 0; k < rfw_reg.size() && k < n && k < ack_cyc.size(); k++) begin
            checkOutput("rfw_reg", rfw_reg[k], exp_idx[k]);
            checkOutput("rfw_data", rfw_data[k], exp_data[k]);
            checkOutput("rfw_timing", rfw_cyc[k], ack_cyc[k] + 1);
        end
        checkOutput("done_count", done_count - done_before, 1);
        for (int j = 0; j < NREGS; j++) checkOutput("rf_final", rf[j], exp_rf[j]);
        if (!d) for (int k = 0; k < n; k++) checkOutput("mem_final", mem[exp_addr[k]], exp_data[k]);
        checkOutput("stability", stab_err, 0);
        checkOutput("rf_we_idle", rfwe_idle_err, 0);
    endtask

    // Reset lands while the second request of a full restore is outstanding.
    task automatic resetMidRestore();
        int done_before;
        ack_mode = 0;
        clearLogs();
        for (int j = 0; j < NREGS; j++) exp_rf[j] = rf[j];
        done_before = done_count;
        start = 1'b1; dir = 1'b1; mask = 8'hFF; base_addr = 16'($urandom);
        tick();
        start = 1'b0;
        tick();
        checkOutput("rst_pre_we", rf_write_en, 1);
        checkOutput("rst_pre_xfer", xfer_count, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_we", rf_write_en, 0);
        checkOutput("rst_xfer", xfer_count, 0);
        checkOutput("rst_addr", mem_addr, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("rst_no_rfw", rfw_reg.size(), 0);
        checkOutput("rst_no_done", done_count - done_before, 0);
        for (int j = 0; j < NREGS; j++) checkOutput("rst_rf", rf[j], exp_rf[j]);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; req_cycles = 0; done_count = 0;
        stab_err = 0; rfwe_idle_err = 0; ack_mode = 0; req_ctr = 0;
        held = 1'b0; held_we = 1'b0; held_addr = '0; held_data = '0;
        pend_rf = 1'b0; pend_mem = 1'b0; pend_reg = '0;
        pend_rf_data = '0; pend_mem_addr = '0; pend_mem_data = '0;
        rst = 1'b1; start = 1'b0; dir = 1'b0; mask = '0; base_addr = '0; mem_ack = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        for (int j = 0; j < NREGS; j++) rf[j] = 16'($urandom);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_req", mem_req, 0);
        checkOutput("reset_we", mem_we, 0);
        checkOutput("reset_rfwe", rf_write_en, 0);
        checkOutput("reset_xfer", xfer_count, 0);
        checkOutput("reset_addr", mem_addr, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] directed save");
        for (int i = 0; i < NREGS; i++) rf[i] = 16'h1000 + 16'(i);
        applyStimulus(1'b0, 8'b1010_0101, 16'h0100, 0, 1'b0);
        checkOutput("save_last_word", mem[16'h0103], 16'h1007);

        $display("[TB] directed restore");
        mem[16'h0200] = 16'hBEEF;
        mem[16'h0201] = 16'hCAFE;
        applyStimulus(1'b1, 8'b0000_0110, 16'h0200, 0, 1'b0);
        checkOutput("restore_r1", rf[1], 16'hBEEF);
        checkOutput("restore_r2", rf[2], 16'hCAFE);

        $display("[TB] wait states, empty mask, wrap, busy start");
        applyStimulus(1'b0, 8'h01, 16'h0300, 2, 1'b0);
        applyStimulus(1'b0, 8'h00, 16'h0400, 0, 1'b0);
        applyStimulus(1'b1, 8'h00, 16'h0500, 0, 1'b0);
        applyStimulus(1'b0, 8'h03, 16'hFFFF, 0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 16'($urandom), 0, 1'b1);

        $display("[TB] reset mid restore");
        resetMidRestore();
        applyStimulus(1'b1, 8'($urandom), 16'($urandom), 0, 1'b0);

        $display("[TB] random commands");
        repeat (40) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_block_mover.md
Name: reg_block_mover

Overview:
- Multi-register save/restore sequencer for the 16-bit custom CPU. It is the initiator side of the register-file read/write interface.
- For a given register bitmask, it walks the set registers in ascending index order. Save (STM) reads each register and writes it to consecutive memory words. Restore (LDM) reads consecutive memory words and writes them into the register file.
- Sits between the control unit (start/done), the register file ports and the data-memory request/ack port.

Parameters:
- WORD_SIZE, 16, data and address width.
- REG_BITS, 3, register index width; NREGS = 2**REG_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- dir  in  1  0 = save (regfile→mem), 1 = restore (mem→regfile); sampled with start.
- mask  in  NREGS  register select bitmask; bit i selects register i; sampled with start.
- base_addr  in  WORD_SIZE  first memory address; sampled with start.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- xfer_count  out  REG_BITS+1  registers transferred by the current/last command.
- rf_read_reg  out  REG_BITS  register index to read.
- rf_read_data  in  WORD_SIZE  combinational read data for rf_read_reg.
- rf_write_en  out  1  register write strobe.
- rf_write_reg  out  REG_BITS  register index to write.
- rf_write_data  out  WORD_SIZE  register write data.
- mem_req  out  1  memory request; held until acked.
- mem_we  out  1  1 = memory write (save), 0 = memory read (restore).
- mem_addr  out  WORD_SIZE  memory address.
- mem_wdata  out  WORD_SIZE  memory write data.
- mem_ack  in  1  request accepted/completed on this edge; mem_rdata valid with it.
- mem_rdata  in  WORD_SIZE  memory read data.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; busy, done, mem_req, rf_write_en = 0.
  - xfer_count=0; pending mask, address, rf_*/mem_* data/index registers = 0.
- State IDLE:
  - On start with mask≠0: latch pending=mask, addr=base_addr, dir; clear xfer_count; go REQ.
  - On start with mask=0: clear xfer_count; go DONE; no memory or register-file activity.
- State REQ:
  - Outputs: busy=1; mem_req=1; mem_we=~dir; mem_addr=addr.
  - Index: idx = lowest set bit of pending; rf_read_reg=idx.
  - Save: mem_wdata = rf_read_data (combinational pass-through, stable while idx unchanged).
  - mem_req stays high with address and data stable until mem_ack is sampled high.
- Each edge with mem_ack=1 in REQ:
  - Clear bit idx in pending.
  - addr ← addr+1, modulo 2**WORD_SIZE; wraps 0xFFFF → 0x0000.
  - xfer_count ← xfer_count+1.
  - Restore only: register rf_write_reg=idx and rf_write_data=mem_rdata, and set rf_write_en=1 for exactly the next cycle.
  - If the cleared pending is zero, go DONE; otherwise stay in REQ. The next request is issued back-to-back, so mem_req does not drop between registers.
- State DONE:
  - busy=1, done=1 for one cycle, then IDLE.
  - A restore's final rf_write_en coincides with the DONE cycle, so the register file is updated when done falls.
- Latency with zero-wait memory (mem_ack tied 1):
  - Start edge T0 → REQ cycles T1..TN → done in cycle N+1.
  - Total N+2 cycles including the start cycle.
- rf_write_en is never asserted in save mode or in IDLE.
- start while busy (REQ or DONE) is ignored and does not disturb the latched command.
- mem_ack outside REQ is ignored.
- Reset mid-operation: everything clears per the reset list, including the pending mask and any scheduled rf_write_en. No partial completion or done pulse is generated.

Decomposition:
- Shared package/define file: WORD_SIZE, REG_BITS, NREGS, the state encoding (IDLE, REQ, DONE) and the DIR_SAVE/DIR_RESTORE constants.
- One sub-module, lowest_set_bit: combinational priority encoder. Input NREGS-bit vector; outputs REG_BITS-bit index and a valid flag. Used for idx selection.

Test Plan:
- Save, mask=8'b1010_0101, base=0x0100, regs r0..r7 = 0x1000+i, mem_ack=1:
  - mem writes (0x0100,0x1000), (0x0101,0x1002), (0x0102,0x1005), (0x0103,0x1007).
  - done in cycle 5; xfer_count=4; rf_write_en never high.
- Restore, mask=8'b0000_0110, base=0x0200, mem[0x0200]=0xBEEF, mem[0x0201]=0xCAFE:
  - r1=0xBEEF, r2=0xCAFE; each rf_write_en exactly one cycle after its ack; others unchanged.
- Wait states, save mask=0x01, mem_ack asserted after 3 cycles:
  - mem_req high 4 cycles with addr/data stable; one write; done one cycle after the ack.
- Empty mask and wrap:
  - mask=0x00 → done in cycle 1, mem_req never high, xfer_count=0.
  - Save mask=0x03, base=0xFFFF → addresses 0xFFFF then 0x0000.
- Busy/reset:
  - start pulsed during a save → ignored, original sequence completes.
  - rst asserted during the second request of a restore (mask=0xFF) → outputs 0 immediately, no further rf writes, no done; a new command then runs normally.
